ahb_arbiter: RTL and testbench

- Round-robin AHB-Lite bus arbiter that shares one slave path (ROM and the other memory-mapped slaves) between up to 4 bus masters.
- Samples master requests and issues a registered one-hot grant.
- Tracks the owner's transfers to cap burst occupancy, and drives HMASTER to select the owning master's address/control/write-data mux.
- Sits between the masters and the address decoder / slave mux.

---
 rtl/ahb_arbiter.sv | 130 +++++++++++++
 tb/tb_ahb_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/ahb_arbiter.sv
// Round-robin AHB-Lite arbiter for up to 4 masters with a per-tenure beat cap.
// Optional master locking is compiled in with AHB_ARB_LOCK_EN.
//
// state | meaning
// PARK  | DEFAULT_MASTER holds the grant, no request pending
// OWN   | a requesting master owns the bus; beats counted toward MAX_BEATS
module ahb_arbiter #(
   parameter int NUM_MASTERS    = 3,
   parameter int DEFAULT_MASTER = 0,
   parameter int MAX_BEATS      = 4
) (
   input  logic                   HCLK,
   input  logic                   HREST,
   input  logic [NUM_MASTERS-1:0] HBUSREQ,
   input  logic [NUM_MASTERS-1:0] HLOCK,
   input  logic [1:0]             HTRANS,
   input  logic                   HREADY,
   output logic [NUM_MASTERS-1:0] HGRANT,
   output logic [1:0]             HMASTER,
   output logic                   HMASTLOCK
);

   localparam logic [NUM_MASTERS-1:0] DEF_GRANT = NUM_MASTERS'(1) << DEFAULT_MASTER;
   localparam logic [3:0]             MAX_B     = 4'(MAX_BEATS);

   typedef enum logic {PARK, OWN} state_t;

   state_t                   state, state_nx;
   logic [NUM_MASTERS-1:0]   grant_nx;
   logic [3:0]               beat_cnt, beat_nx, beats_now;
   logic [1:0]               rr_ptr, rr_nx, winner, grant_idx;
   logic                     win_found;
   logic                     any_req, owner_req, other_req, owner_lock, rearb;

   assign any_req   = |HBUSREQ;
   assign owner_req = |(HBUSREQ & HGRANT);
   assign other_req = |(HBUSREQ & ~HGRANT);

`ifdef AHB_ARB_LOCK_EN
   assign owner_lock = |(HLOCK & HGRANT);
`else
   logic unused_lock;
   assign unused_lock = ^HLOCK;
   assign owner_lock  = 1'b0;
`endif

   // Search masters above rr_ptr first, then wrap; rr_ptr itself comes last.
   always_comb begin
      winner    = rr_ptr;
      win_found = 1'b0;
      for (int m = 0; m < NUM_MASTERS; m++) begin
         if (!win_found && HBUSREQ[m] && (m > int'(rr_ptr))) begin
            winner    = 2'(m);
            win_found = 1'b1;
         end
      end
      for (int m = 0; m < NUM_MASTERS; m++) begin
         if (!win_found && HBUSREQ[m] && (m <= int'(rr_ptr))) begin
            winner    = 2'(m);
            win_found = 1'b1;
         end
      end
   end

   always_comb begin
      grant_idx = 2'd0;
      for (int m = 0; m < NUM_MASTERS; m++) begin
         if (HGRANT[m]) grant_idx = 2'(m);
      end
   end

   always_comb begin
      beats_now = beat_cnt;
      if (HTRANS == 2'b10) beats_now = 4'd1;
      else if (HTRANS == 2'b11 && beat_cnt != 4'hf) beats_now = beat_cnt + 4'd1;
   end

   assign rearb = !owner_lock && (!owner_req || (beats_now >= MAX_B && other_req));

   always_comb begin
      state_nx = state;
      grant_nx = HGRANT;
      beat_nx  = beat_cnt;
      rr_nx    = rr_ptr;
      unique case (state)
         PARK: begin
            if (any_req) begin
               state_nx = OWN;
               grant_nx = NUM_MASTERS'(1) << winner;
               rr_nx    = winner;
               beat_nx  = 4'd0;
            end
         end
         OWN: begin
            beat_nx = beats_now;
            if (rearb) begin
               beat_nx = 4'd0;
               if (any_req) begin
                  grant_nx = NUM_MASTERS'(1) << winner;
                  rr_nx    = winner;
               end else begin
                  grant_nx = DEF_GRANT;
                  state_nx = PARK;
               end
            end
         end
         default: state_nx = PARK;
      endcase
   end

   // HREADY low freezes everything so a wait-stated transfer never loses its grant.
   always_ff @(posedge HCLK or posedge HREST) begin
      if (HREST) begin
         state     <= PARK;
         HGRANT    <= DEF_GRANT;
         HMASTER   <= 2'(DEFAULT_MASTER);
         HMASTLOCK <= 1'b0;
         beat_cnt  <= 4'd0;
         rr_ptr    <= 2'(DEFAULT_MASTER);
      end else if (HREADY) begin
         state     <= state_nx;
         HGRANT    <= grant_nx;
         HMASTER   <= grant_idx;
         HMASTLOCK <= owner_lock;
         beat_cnt  <= beat_nx;
         rr_ptr    <= rr_nx;
      end
   end

endmodule

// File: tb/tb_ahb_arbiter.sv
// Scoreboard bench for ahb_arbiter: directed scenarios then random traffic,
// checked against a tenure-level reference model.
module tb_ahb_arbiter;

   localparam int N    = 3;
   localparam int DEF  = 0;
   localparam int MAXB = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         rst_req = 1'b1;
   logic [N-1:0] hbusreq = '0;
   logic [N-1:0] hlock = '0;
   logic [1:0]   htrans = 2'b00;
   logic         hready = 1'b1;
   logic [N-1:0] hgrant;
   logic [1:0]   hmaster;
   logic         hmastlock;

   int n_checks = 0;
   int n_err    = 0;

   typedef struct {
      logic [N-1:0] g;
      logic [1:0]   m;
      logic         l;
   } exp_t;
   exp_t sb[$];

   // reference model: who owns the bus and how many beats this tenure has used
   int m_owner = DEF, m_rr = DEF, m_beats = 0, m_hmaster = DEF;
   bit m_park = 1'b1, m_lock = 1'b0;

   ahb_arbiter #(.NUM_MASTERS(N), .DEFAULT_MASTER(DEF), .MAX_BEATS(MAXB)) dut (
      .HCLK(clk), .HREST(rst), .HBUSREQ(hbusreq), .HLOCK(hlock), .HTRANS(htrans),
      .HREADY(hready), .HGRANT(hgrant), .HMASTER(hmaster), .HMASTLOCK(hmastlock)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // requester with the smallest cyclic distance after rr wins; rr itself is farthest
   function automatic int pick(input logic [N-1:0] req, input int rr);
      int best = -1, best_d = 2 * N;
      for (int m = 0; m < N; m++) begin
         int d;
         d = (m - rr - 1 + 2 * N) % N;
         if (req[m] && d < best_d) begin
            best   = m;
            best_d = d;
         end
      end
      return best;
   endfunction

   task automatic model_reset();
      m_park = 1'b1; m_owner = DEF; m_rr = DEF; m_beats = 0; m_hmaster = DEF; m_lock = 1'b0;
   endtask

   task automatic model_step(input logic [N-1:0] req, input logic [N-1:0] lk,
                             input logic [1:0] tr, input logic rdy);
      bit held;
      int w;
      if (rst) begin
         model_reset();
         return;
      end
      if (!rdy) return;
      m_hmaster = m_owner;
`ifdef AHB_ARB_LOCK_EN
      held   = lk[m_owner];
      m_lock = lk[m_owner];
`else
      held   = 1'b0;
      m_lock = 1'b0;
`endif
      if (m_park) begin
         if (req != 0) begin
            w = pick(req, m_rr);
            m_owner = w; m_rr = w; m_park = 1'b0; m_beats = 0;
         end
      end else begin
         if (tr == 2'b10) m_beats = 1;
         else if (tr == 2'b11 && m_beats < 15) m_beats++;
         if (!held && (!req[m_owner] ||
                       (m_beats >= MAXB && (req & ~(3'b001 << m_owner)) != 0))) begin
            m_beats = 0;
            if (req == 0) begin
               m_park = 1'b1; m_owner = DEF;
            end else begin
               w = pick(req, m_rr);
               m_owner = w; m_rr = w;
            end
         end
      end
   endtask

   function automatic exp_t expect_now();
      exp_t e;
      e.g = 3'b001 << m_owner;
      e.m = 2'(m_hmaster);
      e.l = m_lock;
      return e;
   endfunction

   task automatic cyc(input logic [N-1:0] req, input logic [N-1:0] lk,
                      input logic [1:0] tr, input logic rdy);
      @(negedge clk);
      rst = rst_req;
      hbusreq = req; hlock = lk; htrans = tr; hready = rdy;
      model_step(req, lk, tr, rdy);
      sb.push_back(expect_now());
   endtask

   task automatic async_reset();
      @(negedge clk);
      #2;
      rst_req = 1'b1;
      rst = 1'b1;
      #1;
      chk("async_rst_hgrant", int'(hgrant), 1);
      chk("async_rst_hmaster", int'(hmaster), 0);
      chk("async_rst_hmastlock", int'(hmastlock), 0);
      model_reset();
      sb.push_back(expect_now());
      rst_req = 1'b0;
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("hgrant", int'(hgrant), int'(e.g));
            chk("hmaster", int'(hmaster), int'(e.m));
            chk("hmastlock", int'(hmastlock), int'(e.l));
         end
      end
   end

   initial begin : driver
      logic [N-1:0] req;
      repeat (2) cyc(3'b000, 3'b000, 2'b00, 1'b1);
      rst_req = 1'b0;
      cyc(3'b000, 3'b000, 2'b00, 1'b1);

      // single request: grant after 1 edge, HMASTER after 2
      cyc(3'b010, 3'b000, 2'b10, 1'b1);
      cyc(3'b010, 3'b000, 2'b10, 1'b1);
      cyc(3'b010, 3'b000, 2'b11, 1'b1);

      async_reset();
      cyc(3'b000, 3'b000, 2'b00, 1'b1);

      // burst cap with a wait-stated handover
      cyc(3'b001, 3'b000, 2'b00, 1'b1);
      cyc(3'b101, 3'b000, 2'b10, 1'b1);
      cyc(3'b101, 3'b000, 2'b11, 1'b1);
      cyc(3'b101, 3'b000, 2'b11, 1'b1);
      repeat (3) cyc(3'b101, 3'b000, 2'b11, 1'b0);
      cyc(3'b101, 3'b000, 2'b11, 1'b1);
      cyc(3'b101, 3'b000, 2'b11, 1'b1);
      repeat (4) cyc(3'b100, 3'b000, 2'b11, 1'b1);
      cyc(3'b001, 3'b000, 2'b10, 1'b1);
      cyc(3'b001, 3'b000, 2'b11, 1'b1);

      // owner drops while another raises: immediate handover
      cyc(3'b010, 3'b000, 2'b11, 1'b1);
      cyc(3'b010, 3'b000, 2'b10, 1'b1);

      // all masters requesting: strict rotation
      repeat (26) cyc(3'b111, 3'b000, 2'b11, 1'b1);
      repeat (2) cyc(3'b000, 3'b000, 2'b00, 1'b1);

`ifdef AHB_ARB_LOCK_EN
      async_reset();
      cyc(3'b010, 3'b000, 2'b10, 1'b1);
      cyc(3'b111, 3'b010, 2'b10, 1'b1);
      repeat (7) cyc(3'b111, 3'b010, 2'b11, 1'b1);
      cyc(3'b111, 3'b000, 2'b11, 1'b1);
      repeat (3) cyc(3'b111, 3'b000, 2'b11, 1'b1);
`endif

      req = 3'b000;
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 3) == 0) req = 3'($urandom_range(0, 7));
         cyc(req,
             ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'b000,
             2'($urandom_range(0, 3)),
             $urandom_range(0, 3) != 0);
      end

      repeat (3) @(posedge clk);
      #2;
      chk("sb_drain", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
